// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus STABLE/CHECK qualification FSM for one asynchronous input.
// Output changes STABLE_CYCLES+2 edges after a held input change; rejected candidates are counted.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signal,
  output logic                debounced,
  output logic                checking,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                debounced_q, debounced_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_STABLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      debounced_q <= 1'b0;
      glitch_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
      glitch_q    <= glitch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = signal;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    debounced_d = debounced_q;
    glitch_d    = glitch_q;

    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync2_q != debounced_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (sync2_q == debounced_q) begin
          // Input fell back before qualifying: reject and count, saturating.
          state_d = ST_STABLE;
          cnt_d   = '0;
          if (glitch_q != {GLITCH_W{1'b1}}) begin
            glitch_d = glitch_q + 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_STABLE;
          cnt_d       = '0;
          debounced_d = ~debounced_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign debounced    = debounced_q;
  assign checking     = (state_q == ST_CHECK);
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: expected output events queued at stimulus time, matched by a negedge monitor.
module tb_input_debouncer;

  localparam int SC  = 4;
  localparam int GW  = 4;
  localparam int LAT = SC + 2;            // drive after edge k -> output change after edge k+LAT
  localparam int GMAX = (1 << GW) - 1;

  logic          clk;
  logic          rst;
  logic          signal;
  logic          debounced;
  logic          checking;
  logic [GW-1:0] glitch_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_gc = 0;

  typedef struct {
    int kind;   // 0: debounced change, 1: glitch_count change
    int val;
    int cyc;
  } ev_t;

  ev_t sb[$];

  logic          prev_deb;
  logic [GW-1:0] prev_gc;

  input_debouncer #(
    .STABLE_CYCLES(SC),
    .GLITCH_W     (GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signal      (signal),
    .debounced   (debounced),
    .checking    (checking),
    .glitch_count(glitch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output event monitor: every observed change must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      prev_deb = debounced;
      prev_gc  = glitch_count;
    end else begin
      if (debounced !== prev_deb) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_deb_unexpected: got debounced=%0b at cyc %0d, required no change", debounced, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != 0 || e.val != int'(debounced) || e.cyc != cyc) begin
            bad++;
            $display("FAIL sb_deb: got kind=0 val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                     debounced, cyc, e.kind, e.val, e.cyc);
          end
        end
        prev_deb = debounced;
      end
      if (glitch_count !== prev_gc) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_glitch_unexpected: got glitch_count=%0d at cyc %0d, required no change", glitch_count, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != 1 || e.val != int'(glitch_count) || e.cyc != cyc) begin
            bad++;
            $display("FAIL sb_glitch: got kind=1 val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                     glitch_count, cyc, e.kind, e.val, e.cyc);
          end
        end
        prev_gc = glitch_count;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse of p cycles starting after the current edge, then gap low cycles.
  task automatic drive_pulse(input int p, input int gap);
    int k;
    k = cyc;
    signal = 1'b1;
    if (p >= SC) begin
      sb.push_back('{0, 1, k + LAT});
      sb.push_back('{0, 0, k + p + LAT});
    end else if (model_gc < GMAX) begin
      model_gc++;
      sb.push_back('{1, model_gc, k + p + 3});
    end
    step(p);
    signal = 1'b0;
    step(gap);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      step(1);
      signal = ~signal;
      total++;
      if (debounced !== 1'b0) begin bad++; $display("FAIL reset_deb: got %0b, required 0", debounced); end
      total++;
      if (checking !== 1'b0) begin bad++; $display("FAIL reset_chk: got %0b, required 0", checking); end
      total++;
      if (glitch_count !== '0) begin bad++; $display("FAIL reset_gc: got %0d, required 0", glitch_count); end
    end
    signal = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_rise_fall();
    int k;
    k = cyc;
    signal = 1'b1;
    sb.push_back('{0, 1, k + LAT});
    step(2);
    total++;
    if (checking !== 1'b0) begin bad++; $display("FAIL rise_chk_early: got %0b, required 0", checking); end
    step(1);
    total++;
    if (checking !== 1'b1) begin bad++; $display("FAIL rise_chk_enter: got %0b, required 1", checking); end
    step(2);
    total++;
    if (debounced !== 1'b0) begin bad++; $display("FAIL rise_deb_early: got %0b, required 0", debounced); end
    step(1);
    total++;
    if (debounced !== 1'b1) begin bad++; $display("FAIL rise_deb: got %0b, required 1", debounced); end
    total++;
    if (checking !== 1'b0) begin bad++; $display("FAIL rise_chk_exit: got %0b, required 0", checking); end
    total++;
    if (glitch_count !== GW'(model_gc)) begin bad++; $display("FAIL rise_gc: got %0d, required %0d", glitch_count, model_gc); end
    step(3);
    k = cyc;
    signal = 1'b0;
    sb.push_back('{0, 0, k + LAT});
    step(LAT - 1);
    total++;
    if (debounced !== 1'b1) begin bad++; $display("FAIL fall_deb_early: got %0b, required 1", debounced); end
    step(1);
    total++;
    if (debounced !== 1'b0) begin bad++; $display("FAIL fall_deb: got %0b, required 0", debounced); end
    step(3);
  endtask

  task automatic test_bounce();
    int k;
    k = cyc;
    signal = 1'b1;
    step(3);
    signal = 1'b0;
    model_gc++;
    sb.push_back('{1, model_gc, k + 6});
    step(2);
    k = cyc;
    signal = 1'b1;
    sb.push_back('{0, 1, k + LAT});
    step(LAT + 2);
    total++;
    if (glitch_count !== GW'(model_gc)) begin bad++; $display("FAIL bounce_gc: got %0d, required %0d", glitch_count, model_gc); end
    total++;
    if (debounced !== 1'b1) begin bad++; $display("FAIL bounce_deb: got %0b, required 1", debounced); end
    k = cyc;
    signal = 1'b0;
    sb.push_back('{0, 0, k + LAT});
    step(LAT + 3);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) drive_pulse(2, 6);
    step(4);
    total++;
    if (glitch_count !== GW'(GMAX)) begin bad++; $display("FAIL sat_gc: got %0d, required %0d", glitch_count, GMAX); end
    total++;
    if (debounced !== 1'b0) begin bad++; $display("FAIL sat_deb: got %0b, required 0", debounced); end
  endtask

  task automatic test_reset_mid();
    int j;
    signal = 1'b1;
    step(4);
    total++;
    if (checking !== 1'b1) begin bad++; $display("FAIL rstmid_chk_before: got %0b, required 1", checking); end
    rst = 1'b1;
    #1;
    model_gc = 0;
    total++;
    if (checking !== 1'b0) begin bad++; $display("FAIL rstmid_chk: got %0b, required 0", checking); end
    total++;
    if (glitch_count !== '0) begin bad++; $display("FAIL rstmid_gc: got %0d, required 0", glitch_count); end
    total++;
    if (debounced !== 1'b0) begin bad++; $display("FAIL rstmid_deb: got %0b, required 0", debounced); end
    step(3);
    rst = 1'b0;
    j = cyc;
    sb.push_back('{0, 1, j + LAT});
    step(LAT - 1);
    total++;
    if (debounced !== 1'b0) begin bad++; $display("FAIL rstmid_deb_early: got %0b, required 0", debounced); end
    step(1);
    total++;
    if (debounced !== 1'b1) begin bad++; $display("FAIL rstmid_deb_rise: got %0b, required 1", debounced); end
    j = cyc;
    signal = 1'b0;
    sb.push_back('{0, 0, j + LAT});
    step(LAT + 3);
  endtask

  task automatic test_boundary();
    drive_pulse(SC, 10);
    total++;
    if (glitch_count !== GW'(model_gc)) begin bad++; $display("FAIL bnd4_gc: got %0d, required %0d", glitch_count, model_gc); end
    drive_pulse(SC - 1, 10);
    total++;
    if (glitch_count !== GW'(model_gc)) begin bad++; $display("FAIL bnd3_gc: got %0d, required %0d", glitch_count, model_gc); end
    total++;
    if (debounced !== 1'b0) begin bad++; $display("FAIL bnd3_deb: got %0b, required 0", debounced); end
  endtask

  initial begin
    rst    = 1'b1;
    signal = 1'b0;
    prev_deb = 1'b0;
    prev_gc  = '0;
    test_reset();
    test_rise_fall();
    test_bounce();
    test_saturation();
    test_reset_mid();
    test_boundary();
    step(4);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending events, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
